// File: rtl/stage_m_if.sv
// Data-bus interface between the M stage (master) and data memory (slave).
// The request, address, write data and byte enables come from the stage;
// the acknowledge and read data come back from memory.
interface stage_m_if;
  logic        DReq;
  logic        DWrite;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic [3:0]  DByteEn;
  logic        DAck;
  logic [31:0] DRData;

  modport master (
    output DReq, DWrite, DAddr, DWData, DByteEn,
    input  DAck, DRData
  );

  modport slave (
    input  DReq, DWrite, DAddr, DWData, DByteEn,
    output DAck, DRData
  );
endinterface

// File: rtl/stage_m.sv
// stage_m: E/M pipeline register plus data-memory access stage.
// Loads and stores are issued on a request/acknowledge bus.  A two-state FSM
// (IDLE/WAIT) stalls the pipeline until DAck arrives, or gives up after
// MAX_WAIT WAIT cycles, raising a sticky bus-error flag.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned
// half/word accesses and suppress them instead of issuing them.
module stage_m #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // execute-stage results and controls
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [1:0]  MemSizeE,
  input  logic        MemSignedE,
  input  logic        armE,
  input  logic [4:0]  RdE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  // memory-stage outputs
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic        armM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        BusErrM,
  output logic        MisalignM,
  stage_m_if.master   dbus
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        arm;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } em_t;

  typedef enum logic {IDLE, WAIT} state_t;

  em_t         em_reg, em_next;
  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        bus_err_reg;

  logic        access;
  logic        suppressed;
  logic        dreq;
  logic        ack;
  logic        timeout;
  logic        stall;
  logic [3:0]  byte_en;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign em_next = '{reg_write: RegWriteE, mem_write: MemWriteE,
                     result_src: ResultSrcE, mem_size: MemSizeE,
                     mem_signed: MemSignedE, arm: armE, rd: RdE,
                     alu_result: ALUResultE, write_data: WriteDataE,
                     pc_plus4: PCPlus4E};

  // E/M register: load when the stage is not stalled, otherwise hold
  always_ff @(posedge clk) begin
    if (rst)
      em_reg <= '0;
    else if (!stall)
      em_reg <= em_next;
  end

  assign access = em_reg.mem_write | (em_reg.result_src == 2'b01);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_addr;
  // half needs addr[0]=0, word (10/11) needs addr[1:0]=00
  always_comb begin
    misalign_addr = 1'b0;
    if (em_reg.mem_size == 2'b01)
      misalign_addr = em_reg.alu_result[0];
    else if (em_reg.mem_size[1])
      misalign_addr = (em_reg.alu_result[1:0] != 2'b00);
  end
  assign suppressed = access & misalign_addr;
`else
  assign suppressed = 1'b0;
`endif

  assign MisalignM = suppressed;

  // Bus handshake: an acknowledge only counts while a request is out,
  // and an acknowledge in the final wait cycle beats the timeout.
  assign dreq    = ((state_reg == IDLE) & access & ~suppressed) | (state_reg == WAIT);
  assign ack     = dreq & dbus.DAck;
  assign timeout = (state_reg == WAIT) & (cnt_reg == 8'(MAX_WAIT)) & ~dbus.DAck;
  assign stall   = dreq & ~dbus.DAck & ~timeout;

  // FSM next state and wait-counter update
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (access && !suppressed && !dbus.DAck) begin
          state_next = WAIT;
          cnt_next   = 8'd0;
        end
      end
      WAIT: begin
        if (dbus.DAck || timeout)
          state_next = IDLE;
        else
          cnt_next = cnt_reg + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, wait counter and sticky bus error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (timeout)
        bus_err_reg <= 1'b1;
    end
  end

  // Byte enables and lane-replicated write data for the access size
  always_comb begin
    byte_en = 4'b1111;
    wdata   = em_reg.write_data;
    case (em_reg.mem_size)
      2'b00: begin
        byte_en = 4'b0001 << em_reg.alu_result[1:0];
        wdata   = {4{em_reg.write_data[7:0]}};
      end
      2'b01: begin
        byte_en = em_reg.alu_result[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{em_reg.write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed lane of the read data and extend it
  always_comb begin
    load_data = dbus.DRData;
    case (em_reg.mem_size)
      2'b00: begin
        logic [7:0] b;
        case (em_reg.alu_result[1:0])
          2'b00:   b = dbus.DRData[7:0];
          2'b01:   b = dbus.DRData[15:8];
          2'b10:   b = dbus.DRData[23:16];
          default: b = dbus.DRData[31:24];
        endcase
        load_data = {{24{em_reg.mem_signed & b[7]}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h = em_reg.alu_result[1] ? dbus.DRData[31:16] : dbus.DRData[15:0];
        load_data = {{16{em_reg.mem_signed & h[15]}}, h};
      end
      default: ;
    endcase
  end

  assign dbus.DReq    = dreq;
  assign dbus.DWrite  = em_reg.mem_write;
  assign dbus.DAddr   = em_reg.alu_result;
  assign dbus.DByteEn = dreq ? byte_en : 4'b0000;
  assign dbus.DWData  = dreq ? wdata : 32'd0;

  assign ReadDataM  = ack ? load_data : 32'd0;
  assign MemStallM  = stall;
  assign BusErrM    = bus_err_reg | timeout;
  assign RegWriteM  = em_reg.reg_write;
  assign ResultSrcM = em_reg.result_src;
  assign armM       = em_reg.arm;
  assign RdM        = em_reg.rd;
  assign ALUResultM = em_reg.alu_result;
  assign PCPlus4M   = em_reg.pc_plus4;

endmodule

// File: tb/tb_stage_m.sv
// Directed testbench for stage_m: a vector table of single-cycle accesses
// plus hand-written wait, timeout and reset-during-wait sequences.
module tb_stage_m;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteE = 1'b0, MemWriteE = 1'b0;
  logic [1:0]  ResultSrcE = 2'b00, MemSizeE = 2'b00;
  logic        MemSignedE = 1'b0, armE = 1'b0;
  logic [4:0]  RdE = 5'd0;
  logic [31:0] ALUResultE = 32'd0, WriteDataE = 32'd0, PCPlus4E = 32'd0;
  logic        RegWriteM, armM, MemStallM, BusErrM, MisalignM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, PCPlus4M, ReadDataM;

  int tests = 0;
  int failed = 0;

  stage_m_if dbus ();

  stage_m #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .MemSizeE(MemSizeE), .MemSignedE(MemSignedE), .armE(armE), .RdE(RdE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .armM(armM), .RdM(RdM),
    .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
    .MemStallM(MemStallM), .BusErrM(BusErrM), .MisalignM(MisalignM),
    .dbus(dbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [1:0]  rs;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        exp_dreq;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd);
    RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; MemSizeE = sz;
    MemSignedE = sg; armE = 1'b0; RdE = rd; ALUResultE = addr;
    WriteDataE = wd; PCPlus4E = addr + 32'd4;
  endtask

  task automatic drive_nop();
    drive_e(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int n;
    //            mw    rs     sz     sg    addr          wd            rd            dreq  be       exp_wd        exp_rd        mis
    vecs[0]  = '{1'b1, 2'b00, 2'b10, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h00000000, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 2'b00, 1'b0, 32'h00000101, 32'h000000AB, 32'h00000000, 1'b1, 4'b0010, 32'hABABABAB, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 2'b01, 1'b0, 32'h00000102, 32'h0000BEEF, 32'h00000000, 1'b1, 4'b1100, 32'hBEEFBEEF, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 2'b01, 1'b0, 32'h00000102, 32'h00000000, 32'h8001AAAA, 1'b1, 4'b1100, 32'h00000000, 32'h00008001, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 2'b01, 1'b1, 32'h00000100, 32'h00000000, 32'h1234F00D, 1'b1, 4'b0011, 32'h00000000, 32'hFFFFF00D, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 2'b00, 1'b0, 32'h00000103, 32'h00000000, 32'h80FFFFFF, 1'b1, 4'b1000, 32'h00000000, 32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 1'b1, 32'h00000101, 32'h00000000, 32'h00007F00, 1'b1, 4'b0010, 32'h00000000, 32'h0000007F, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 2'b10, 1'b1, 32'h00000104, 32'h00000000, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 2'b11, 1'b0, 32'h00000108, 32'h00000000, 32'h01020304, 1'b1, 4'b1111, 32'h00000000, 32'h01020304, 1'b0};
`ifdef DMEM_MISALIGN_CHECK_EN
    vecs[9]  = '{1'b0, 2'b01, 2'b10, 1'b0, 32'h00000102, 32'h00000000, 32'h11223344, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1};
`else
    vecs[9]  = '{1'b0, 2'b01, 2'b10, 1'b0, 32'h00000102, 32'h00000000, 32'h11223344, 1'b1, 4'b1111, 32'h00000000, 32'h11223344, 1'b0};
`endif
    // no access at all: DAck must be ignored
    vecs[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 32'h00000055, 32'h00000000, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b0};

    dbus.DAck = 1'b0;
    dbus.DRData = 32'd0;

    // reset state
    tick();
    tick();
    #2;
    check("rst_dreq", 32'(dbus.DReq), 32'd0);
    check("rst_stall", 32'(MemStallM), 32'd0);
    check("rst_regwrite", 32'(RegWriteM), 32'd0);
    check("rst_buserr", 32'(BusErrM), 32'd0);
    check("rst_readdata", ReadDataM, 32'd0);
    rst = 1'b0;
    $display("[TB] reset checked");

    // single-cycle accesses: DAck returned in the first M cycle
    for (int i = 0; i < 11; i++) begin
      tick();
      drive_e(1'b0, vecs[i].mw, vecs[i].rs, vecs[i].sz, vecs[i].sg, 5'(i + 1),
              vecs[i].addr, vecs[i].wd);
      tick();
      drive_nop();
      dbus.DAck = 1'b1;
      dbus.DRData = vecs[i].rd;
      #2;
      check($sformatf("v%0d_dreq", i), 32'(dbus.DReq), 32'(vecs[i].exp_dreq));
      check($sformatf("v%0d_byteen", i), 32'(dbus.DByteEn), 32'(vecs[i].exp_be));
      check($sformatf("v%0d_wdata", i), dbus.DWData, vecs[i].exp_wd);
      check($sformatf("v%0d_readdata", i), ReadDataM, vecs[i].exp_rd);
      check($sformatf("v%0d_stall", i), 32'(MemStallM), 32'd0);
      check($sformatf("v%0d_misalign", i), 32'(MisalignM), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_daddr", i), dbus.DAddr, vecs[i].addr);
      check($sformatf("v%0d_dwrite", i), 32'(dbus.DWrite), 32'(vecs[i].mw));
      check($sformatf("v%0d_rdm", i), 32'(RdM), i + 1);
      check($sformatf("v%0d_pc4", i), PCPlus4M, vecs[i].addr + 32'd4);
      $display("[TB] vector %0d addr=%h be=%b rdata=%h", i, vecs[i].addr, dbus.DByteEn, ReadDataM);
      tick();
      dbus.DAck = 1'b0;
      dbus.DRData = 32'd0;
      #2;
      check($sformatf("v%0d_idle_after", i), 32'(dbus.DReq), 32'd0);
    end

    // signed byte load with DAck after three stall cycles
    drive_e(1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 5'd9, 32'h00000103, 32'd0);
    tick();
    drive_nop();
    #2;
    check("wait_c1_stall", 32'(MemStallM), 32'd1);
    check("wait_c1_byteen", 32'(dbus.DByteEn), 32'b1000);
    tick();
    #2;
    check("wait_c2_stall", 32'(MemStallM), 32'd1);
    check("wait_c2_regwrite_held", 32'(RegWriteM), 32'd1);
    tick();
    #2;
    check("wait_c3_stall", 32'(MemStallM), 32'd1);
    check("wait_c3_daddr", dbus.DAddr, 32'h00000103);
    check("wait_c3_readdata", ReadDataM, 32'd0);
    tick();
    dbus.DAck = 1'b1;
    dbus.DRData = 32'h80FFFFFF;
    #2;
    check("wait_ack_stall", 32'(MemStallM), 32'd0);
    check("wait_ack_readdata", ReadDataM, 32'hFFFFFF80);
    tick();
    dbus.DAck = 1'b0;
    dbus.DRData = 32'd0;
    #2;
    check("wait_after_dreq", 32'(dbus.DReq), 32'd0);
    check("wait_after_regwrite", 32'(RegWriteM), 32'd0);
    $display("[TB] wait sequence readdata check done");

    // load never acknowledged: 1 IDLE + 15 WAIT stall cycles, then timeout
    drive_e(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 5'd3, 32'h00000200, 32'd0);
    tick();
    drive_nop();
    #2;
    n = 0;
    while (MemStallM && n < 100) begin
      n++;
      tick();
      #2;
    end
    check("timeout_stall_cycles", n, 16);
    check("timeout_dreq", 32'(dbus.DReq), 32'd1);
    check("timeout_readdata", ReadDataM, 32'd0);
    check("timeout_buserr", 32'(BusErrM), 32'd1);
    tick();
    #2;
    check("timeout_idle", 32'(dbus.DReq), 32'd0);
    tick();
    tick();
    #2;
    check("buserr_sticky", 32'(BusErrM), 32'd1);
    $display("[TB] timeout after %0d stall cycles", n);

    // reset arriving in the second WAIT cycle
    drive_e(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 5'd4, 32'h00000300, 32'd0);
    tick();
    drive_nop();
    tick();
    tick();
    #2;
    check("midwait_stall_before", 32'(MemStallM), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("midwait_dreq", 32'(dbus.DReq), 32'd0);
    check("midwait_stall", 32'(MemStallM), 32'd0);
    check("midwait_regwrite", 32'(RegWriteM), 32'd0);
    check("midwait_buserr", 32'(BusErrM), 32'd0);
    $display("[TB] reset mid-wait checked");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
